// File: rtl/spd_slew_lim.sv
`default_nettype none
// ============================================================================
// Module      : spd_slew_lim
// Description : Ramps signed left/right wheel speeds toward captured targets in
//               fixed steps per tick, with a fast-decel emergency stop.
// Revision    : 1.0 - initial release
// ============================================================================
module spd_slew_lim #(
    parameter logic [10:0] STEP       = 11'd4,
    parameter logic [10:0] ESTOP_STEP = 11'd32,
    parameter int          TICK_DIV   = 2048,
    parameter logic [10:0] MAX_SPD    = 11'd1023
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tgt_vld,
    input  logic signed [10:0] lft_tgt,
    input  logic signed [10:0] rght_tgt,
    input  logic               moving,
    input  logic               estop,
    output logic signed [10:0] lft_spd,
    output logic signed [10:0] rght_spd,
    output logic               settled,
    output logic               ramping
);

    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2,
        ESTOP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CW-1:0]       r_cnt;
    logic                w_tick;
    logic signed [10:0]  r_lft_cap;
    logic signed [10:0]  r_rght_cap;
    logic signed [10:0]  w_lft_eff;
    logic signed [10:0]  w_rght_eff;
    logic signed [10:0]  w_lft_goal;
    logic signed [10:0]  w_rght_goal;
    logic [10:0]         w_step;
    logic signed [10:0]  w_lft_stp;
    logic signed [10:0]  w_rght_stp;
    logic signed [10:0]  w_lft_nxt;
    logic signed [10:0]  w_rght_nxt;
    logic                w_fast;

    function automatic logic signed [10:0] clip(input logic signed [10:0] t);
        logic signed [11:0] te;
        logic signed [11:0] mx;
        te = {t[10], t};
        mx = $signed({1'b0, MAX_SPD});
        if (te > mx)
            return 11'(mx);
        else if (te < -mx)
            return 11'(-mx);
        else
            return t;
    endfunction

    // 12-bit difference so a full-scale reversal cannot wrap.
    function automatic logic signed [10:0] step_to(input logic signed [10:0] cur,
                                                   input logic signed [10:0] tgt,
                                                   input logic [10:0]        s);
        logic signed [11:0] c;
        logic signed [11:0] d;
        logic signed [11:0] ss;
        c  = {cur[10], cur};
        d  = {tgt[10], tgt} - c;
        ss = $signed({1'b0, s});
        if (d > ss)
            return 11'(c + ss);
        else if (d < -ss)
            return 11'(c - ss);
        else
            return tgt;
    endfunction

    assign w_tick     = (r_cnt == CW'(TICK_DIV - 1));
    assign w_lft_eff  = moving ? r_lft_cap  : 11'sd0;
    assign w_rght_eff = moving ? r_rght_cap : 11'sd0;
    assign w_fast     = estop || (r_state == ESTOP);
    assign w_step     = w_fast ? ESTOP_STEP : STEP;
    assign w_lft_goal = w_fast ? 11'sd0 : w_lft_eff;
    assign w_rght_goal = w_fast ? 11'sd0 : w_rght_eff;
    assign w_lft_stp  = step_to(lft_spd,  w_lft_goal,  w_step);
    assign w_rght_stp = step_to(rght_spd, w_rght_goal, w_step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (w_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_cap  <= '0;
            r_rght_cap <= '0;
        end else if (estop) begin
            r_lft_cap  <= '0;
            r_rght_cap <= '0;
        end else if (tgt_vld) begin
            r_lft_cap  <= clip(lft_tgt);
            r_rght_cap <= clip(rght_tgt);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lft_nxt   = lft_spd;
        w_rght_nxt  = rght_spd;
        if (estop) begin
            w_state_nxt = ESTOP;
            if (w_tick) begin
                w_lft_nxt  = w_lft_stp;
                w_rght_nxt = w_rght_stp;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_lft_eff != 11'sd0 || w_rght_eff != 11'sd0)
                        w_state_nxt = RAMP;
                end
                RAMP: begin
                    if (w_tick) begin
                        w_lft_nxt  = w_lft_stp;
                        w_rght_nxt = w_rght_stp;
                    end
                    // Settling is judged on the post-update speeds.
                    if (w_lft_nxt == w_lft_eff && w_rght_nxt == w_rght_eff) begin
                        if (w_lft_eff == 11'sd0 && w_rght_eff == 11'sd0)
                            w_state_nxt = IDLE;
                        else
                            w_state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    if (w_lft_eff == 11'sd0 && w_rght_eff == 11'sd0 &&
                        lft_spd == 11'sd0 && rght_spd == 11'sd0)
                        w_state_nxt = IDLE;
                    else if (w_lft_eff != lft_spd || w_rght_eff != rght_spd)
                        w_state_nxt = RAMP;
                end
                ESTOP: begin
                    if (w_tick) begin
                        w_lft_nxt  = w_lft_stp;
                        w_rght_nxt = w_rght_stp;
                    end
                    if (w_lft_nxt == 11'sd0 && w_rght_nxt == 11'sd0)
                        w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            lft_spd  <= '0;
            rght_spd <= '0;
        end else begin
            r_state  <= w_state_nxt;
            lft_spd  <= w_lft_nxt;
            rght_spd <= w_rght_nxt;
        end
    end

    assign settled = (r_state == IDLE) || (r_state == HOLD);
    assign ramping = (r_state == RAMP) || (r_state == ESTOP);

endmodule
`default_nettype wire

// File: tb/tb_spd_slew_lim.sv
`default_nettype none
// ============================================================================
// Module      : tb_spd_slew_lim
// Description : Directed self-checking bench for spd_slew_lim (TICK_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spd_slew_lim;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               tgt_vld = 1'b0;
    logic signed [10:0] lft_tgt = '0;
    logic signed [10:0] rght_tgt = '0;
    logic               moving = 1'b0;
    logic               estop = 1'b0;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               settled;
    logic               ramping;

    int total = 0;
    int bad   = 0;
    int ecnt;

    spd_slew_lim #(
        .STEP       (11'd4),
        .ESTOP_STEP (11'd32),
        .TICK_DIV   (4),
        .MAX_SPD    (11'd1023)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tgt_vld  (tgt_vld),
        .lft_tgt  (lft_tgt),
        .rght_tgt (rght_tgt),
        .moving   (moving),
        .estop    (estop),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .settled  (settled),
        .ramping  (ramping)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; the design's tick edge is every 4th one.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ecnt <= 0;
        else
            ecnt <= ecnt + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (ecnt % 4 == 3)
                found = 1'b1;
        end
        if (!found)
            chk("tick_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic step_tgt(input int l, input int r);
        lft_tgt  = 11'(l);
        rght_tgt = 11'(r);
        tgt_vld  = 1'b1;
        @(posedge clk);
        #1;
        tgt_vld  = 1'b0;
    endtask

    task automatic pulse_on_tick(input int l, input int r);
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (ecnt % 4 == 3)
                found = 1'b1;
        end
        if (!found)
            chk("tick_timeout", 0, 1);
        step_tgt(l, r);
    endtask

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lft", lft_spd, 0);
        chk("rst_rght", rght_spd, 0);
        chk("rst_settled", settled, 1);
        chk("rst_ramping", ramping, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("idle100_lft", lft_spd, 0);
        chk("idle100_settled", settled, 1);
        chk("idle100_ramping", ramping, 0);

        // Ramp up +40 / -20
        moving = 1'b1;
        wait_tick();
        step_tgt(40, -20);
        for (int n = 1; n <= 10; n++) begin
            wait_tick();
            chk("up_lft", lft_spd, (4 * n > 40) ? 40 : 4 * n);
            chk("up_rght", rght_spd, (-4 * n < -20) ? -20 : -4 * n);
            if (n == 1) chk("up_ramping", ramping, 1);
            if (n == 9) chk("up_not_settled", settled, 0);
        end
        chk("up_settled", settled, 1);
        chk("up_ramping_done", ramping, 0);

        // Partial step to 42
        step_tgt(42, -20);
        wait_tick();
        chk("partial_lft", lft_spd, 42);
        chk("partial_settled", settled, 1);

        // -1024 clips to -1023, no overshoot
        step_tgt(-1024, -20);
        for (int n = 1; n <= 267; n++) begin
            wait_tick();
            chk("clip_lft", lft_spd, (42 - 4 * n < -1023) ? -1023 : 42 - 4 * n);
        end
        chk("clip_settled", settled, 1);

        // Back up to +100
        step_tgt(100, -20);
        repeat (281) wait_tick();
        chk("to100_lft", lft_spd, 100);
        chk("to100_settled", settled, 1);

        // Reversal +100 -> -100
        step_tgt(-100, -20);
        for (int n = 1; n <= 50; n++) begin
            wait_tick();
            chk("rev_lft", lft_spd, 100 - 4 * n);
            chk("rev_rght", rght_spd, -20);
        end
        chk("rev_settled", settled, 1);

        // Up to +500, then estop
        step_tgt(500, -20);
        repeat (150) wait_tick();
        chk("to500_lft", lft_spd, 500);
        estop = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            wait_tick();
            chk("estop_lft", lft_spd, (500 - 32 * n < 0) ? 0 : 500 - 32 * n);
            chk("estop_rght", rght_spd, 0);
            chk("estop_ramping", ramping, 1);
            if (n == 4) step_tgt(300, 300);
        end
        repeat (2) wait_tick();
        chk("estop_hold_lft", lft_spd, 0);
        estop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_estop_ramping", ramping, 0);
        chk("post_estop_settled", settled, 1);
        repeat (2) wait_tick();
        chk("post_estop_lft", lft_spd, 0);
        chk("post_estop_rght", rght_spd, 0);

        // tgt_vld on a tick edge uses the old target
        wait_tick();
        step_tgt(40, 40);
        repeat (2) wait_tick();
        chk("pre_edge_lft", lft_spd, 8);
        pulse_on_tick(9, 9);
        chk("edge_old_tgt_lft", lft_spd, 12);
        chk("edge_old_tgt_rght", rght_spd, 12);
        wait_tick();
        chk("edge_new_tgt_lft", lft_spd, 9);
        chk("edge_new_tgt_settled", settled, 1);

        // moving=0 mid-ramp
        step_tgt(100, 100);
        repeat (3) wait_tick();
        chk("mv_pre_lft", lft_spd, 21);
        moving = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            wait_tick();
            chk("mv_lft", lft_spd, (21 - 4 * n < 0) ? 0 : 21 - 4 * n);
        end
        chk("mv_ramping", ramping, 0);
        chk("mv_settled", settled, 1);

        // Async reset mid-ramp
        moving = 1'b1;
        step_tgt(200, 200);
        repeat (5) wait_tick();
        chk("ar_pre_lft", lft_spd, 20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_lft", lft_spd, 0);
        chk("ar_rght", rght_spd, 0);
        chk("ar_settled", settled, 1);
        chk("ar_ramping", ramping, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
